posit_operand_extract: RTL and testbench
========================================

// Module: posit_operand_extract
// PURPOSE
// - Two-stage pipelined posit field extractor that sits directly upstream of the posit adder alignment/arithmetic stage.
// - Takes two raw posit operands per transaction and emits, for each, InRemain, Sign, RegimeValue, Exponent and Mantissa.
// - Output format is exactly what the alignment stage consumes; valid/ready handshake on both sides.
// PARAMETERS
// - N    8        posit width in bits
// - ES   3        exponent field width
// - RS   log2(N)  regime value magnitude width; RegimeValue is RS+1 bits signed
// PORTS
// - clk            in   1        clock, rising edge
// - rst_n          in   1        asynchronous, active-low reset
// - in_valid       in   1        operand pair valid
// - in_ready       out  1        stage can accept the pair this cycle
// - in_a, in_b     in   N        raw posit operands
// - out_valid      out  1        decoded pair valid
// - out_ready      in   1        downstream accepts the pair
// - InRemain1/2    out  N-1      |x|[N-2:0], the two's-complement magnitude without the sign bit
// - Sign1/2        out  1        x[N-1]
// - RegimeValue1/2 out  RS+1     signed regime value k
// - Exponent1/2    out  ES       exponent field, zero-padded if truncated
// - Mantissa1/2    out  N-ES+3   [N-ES+2]=0 guard, [N-ES+1]=hidden 1, below that the fraction left-aligned and zero-filled
// - IsZero1/2      out  1        operand == 0 (see CONFIGURATION)
// - IsNaR1/2       out  1        operand == 1000..0 (see CONFIGURATION)
// BEHAVIOUR
// - Handshake
//   - A transfer occurs on any cycle where valid && ready, on each side independently.
//   - in_ready = ~s1_valid | s1_advance, where s1_advance = ~s2_valid | out_ready.
//   - out_valid is held, and all out_* held stable, until out_ready.
// - Latency: 2 cycles from input transfer to out_valid; throughput is one pair per cycle when out_ready=1.
// - Stage 1 (registered at the end of the cycle)
//   - mag = Sign ? -x : x.
//   - Leading run length of mag[N-2:0]: run bit b, count k in 1..N-1.
// - Stage 2 (registered)
//   - RegimeValue = b ? k-1 : -k.
//   - rem = mag[N-2:0] << (k+1), taking N-1 bits and zero-filling.
//   - Exponent = rem[N-2:N-1-ES].
//   - Mantissa = {1'b0, 1'b1, rem[N-2-ES:0], zeros}.
// - Ordering and pipeline state
//   - Operand A drives the *1 outputs and operand B drives the *2 outputs.
//   - No reordering.
//   - No bubbles are inserted while out_ready=1.
// - Reset values: s1_valid=0, s2_valid=0, out_valid=0, in_ready=1; all data registers cleared to 0.
// - Asynchronous reset mid-transaction drops in-flight pairs; no partial output appears after release.
// - Boundary cases
//   - Full pipe with out_ready=0: in_ready=0 and nothing is overwritten.
//   - Full pipe with out_ready=1: the output, middle and input stages all advance in the same cycle.
//   - k=N-1 (all-ones or all-zeros run): no terminator exists; Exponent=0 and Mantissa fraction=0.
// CONFIGURATION
// - Macro POSIT_EXTRACT_SPECIAL_EN, when defined:
//   - IsZero and IsNaR are decoded in stage 1 and registered alongside the data.
//   - For zero or NaR operands, RegimeValue, Exponent and Mantissa are forced to 0.
// - When undefined:
//   - IsZero and IsNaR are tied to 0.
//   - Zero and NaR pass through the normal decode path with no forcing.
// STRUCTURE
// - Package posit_pkg
//   - localparams N, ES, RS, MW=N-ES+3.
//   - typedef posit_fields_t: struct {remain, sign, regime, exponent, mantissa, is_zero, is_nar}.
//   - function clog2.
// - Sub-module posit_run_length (combinational)
//   - mag[N-2:0] -> run bit and count.
//   - Instantiated twice, once per operand.
// - Top level holds the two pipeline registers of posit_fields_t pairs plus the valid/ready logic.
// TESTING (N=8, ES=3)
// - in_a=8'h40 -> Sign1=0, InRemain1=7'h40, RegimeValue1=0, Exponent1=0, Mantissa1=8'h40, out_valid exactly 2 cycles after transfer.
// - in_a=8'h5A -> RegimeValue1=0, Exponent1=3'd6, Mantissa1=8'h60.
// - in_a=8'hC0 -> Sign1=1, InRemain1=7'h40, RegimeValue1=0, Exponent1=0, Mantissa1=8'h40.
// - in_a=8'h7F -> RegimeValue1=6, Exponent1=0, Mantissa1=8'h40.
// - in_b=8'h01 -> RegimeValue2=-6, Exponent2=0, Mantissa2=8'h40.
// - Back-pressure: stream 4 pairs with out_ready=0 for 5 cycles.
//   - in_ready goes low after 2 accepts.
//   - After release, all 4 pairs emerge in order with no loss or duplication.
// - Mid-stream reset: assert rst_n=0 with 2 pairs in flight.
//   - out_valid drops at once; none of those pairs appear after release.
// - POSIT_EXTRACT_SPECIAL_EN defined:
//   - in_a=8'h00 -> IsZero1=1 with fields forced to 0.
//   - in_b=8'h80 -> IsNaR2=1 with fields forced to 0.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit field-extraction types and sizes.
// Optional build macro: POSIT_EXTRACT_SPECIAL_EN (zero/NaR detection).
package posit_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = clog2(N);
    localparam int MW = N - ES + 3;

    // Zero fill below the fraction inside the mantissa.
    localparam int MPAD = MW - 2 - (N - 1 - ES);

    // Stage-1 bundle: magnitude plus leading-run data.
    typedef struct packed {
        logic [N-2:0]  remain;
        logic          sign;
        logic          run_bit;
        logic [RS-1:0] run_len;
        logic          is_zero;
        logic          is_nar;
    } posit_run_t;

    // Stage-2 bundle: fields in the form the aligner consumes.
    typedef struct packed {
        logic [N-2:0]  remain;
        logic          sign;
        logic [RS:0]   regime;
        logic [ES-1:0] exponent;
        logic [MW-1:0] mantissa;
        logic          is_zero;
        logic          is_nar;
    } posit_fields_t;

endpackage

// File: rtl/posit_run_length.sv
// Leading run detector over the posit magnitude body.
// The run count saturates naturally at N-1 when no terminator exists.
module posit_run_length
    import posit_pkg::*;
(
    input  logic [N-2:0]  i_bits,
    output logic          o_run_bit,
    output logic [RS-1:0] o_run_len
);

    logic w_stop;

    assign o_run_bit = i_bits[N-2];

    // Count identical bits from the MSB until the first change.
    always_comb begin
        o_run_len = '0;
        w_stop    = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_stop) begin
                if (i_bits[i] == i_bits[N-2]) begin
                    o_run_len = o_run_len + RS'(1);
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/posit_operand_extract.sv
// Two-stage posit operand field extractor feeding the adder aligner.
// Build macro POSIT_EXTRACT_SPECIAL_EN enables zero/NaR flags and forcing.
module posit_operand_extract
    import posit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-2:0]  InRemain1,
    output logic [N-2:0]  InRemain2,
    output logic          Sign1,
    output logic          Sign2,
    output logic [RS:0]   RegimeValue1,
    output logic [RS:0]   RegimeValue2,
    output logic [ES-1:0] Exponent1,
    output logic [ES-1:0] Exponent2,
    output logic [MW-1:0] Mantissa1,
    output logic [MW-1:0] Mantissa2,
    output logic          IsZero1,
    output logic          IsZero2,
    output logic          IsNaR1,
    output logic          IsNaR2
);

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    logic          r_s1_valid;
    logic          r_s2_valid;
    posit_run_t    r_s1_a;
    posit_run_t    r_s1_b;
    posit_fields_t r_s2_a;
    posit_fields_t r_s2_b;

    logic          w_s1_advance;
    logic [N-2:0]  w_mag_a;
    logic [N-2:0]  w_mag_b;
    logic          w_bit_a;
    logic          w_bit_b;
    logic [RS-1:0] w_len_a;
    logic [RS-1:0] w_len_b;
    posit_run_t    w_s1_a;
    posit_run_t    w_s1_b;
    posit_fields_t w_s2_a;
    posit_fields_t w_s2_b;

    // Regime, exponent and mantissa from a registered run bundle.
    function automatic posit_fields_t decode(input posit_run_t s);
        posit_fields_t f;
        logic [RS:0]   k;
        logic [RS:0]   sh;
        logic [N-2:0]  rem;
        k          = {1'b0, s.run_len};
        sh         = k + (RS+1)'(1);
        rem        = s.remain << sh;
        f.remain   = s.remain;
        f.sign     = s.sign;
        f.is_zero  = s.is_zero;
        f.is_nar   = s.is_nar;
        if (s.run_bit) begin
            f.regime = k - (RS+1)'(1);
        end else begin
            f.regime = (RS+1)'(0) - k;
        end
        f.exponent = rem[N-2 -: ES];
        f.mantissa = {2'b01, rem[N-2-ES:0], {MPAD{1'b0}}};
`ifdef POSIT_EXTRACT_SPECIAL_EN
        if (s.is_zero || s.is_nar) begin
            f.regime   = '0;
            f.exponent = '0;
            f.mantissa = '0;
        end
`endif
        return f;
    endfunction

    assign w_s1_advance = ~r_s2_valid | out_ready;
    assign in_ready     = ~r_s1_valid | w_s1_advance;
    assign out_valid    = r_s2_valid;

    // Low bits of -x only depend on low bits of x.
    assign w_mag_a = in_a[N-1] ? (N-1)'(0) - in_a[N-2:0]
                               : in_a[N-2:0];
    assign w_mag_b = in_b[N-1] ? (N-1)'(0) - in_b[N-2:0]
                               : in_b[N-2:0];

    posit_run_length u_run_a (
        .i_bits    (w_mag_a),
        .o_run_bit (w_bit_a),
        .o_run_len (w_len_a)
    );

    posit_run_length u_run_b (
        .i_bits    (w_mag_b),
        .o_run_bit (w_bit_b),
        .o_run_len (w_len_b)
    );

    // Assemble the stage-1 bundles, flagging specials when enabled.
    always_comb begin
        w_s1_a         = '0;
        w_s1_b         = '0;
        w_s1_a.remain  = w_mag_a;
        w_s1_a.sign    = in_a[N-1];
        w_s1_a.run_bit = w_bit_a;
        w_s1_a.run_len = w_len_a;
        w_s1_b.remain  = w_mag_b;
        w_s1_b.sign    = in_b[N-1];
        w_s1_b.run_bit = w_bit_b;
        w_s1_b.run_len = w_len_b;
`ifdef POSIT_EXTRACT_SPECIAL_EN
        w_s1_a.is_zero = (in_a == '0);
        w_s1_a.is_nar  = (in_a == NAR);
        w_s1_b.is_zero = (in_b == '0);
        w_s1_b.is_nar  = (in_b == NAR);
`endif
    end

    assign w_s2_a = decode(r_s1_a);
    assign w_s2_b = decode(r_s1_b);

    // Stage 1 register: loads whenever the input side transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a <= w_s1_a;
                r_s1_b <= w_s1_b;
            end
        end
    end

    // Stage 2 register: holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_a <= w_s2_a;
                r_s2_b <= w_s2_b;
            end
        end
    end

    assign InRemain1    = r_s2_a.remain;
    assign Sign1        = r_s2_a.sign;
    assign RegimeValue1 = r_s2_a.regime;
    assign Exponent1    = r_s2_a.exponent;
    assign Mantissa1    = r_s2_a.mantissa;
    assign IsZero1      = r_s2_a.is_zero;
    assign IsNaR1       = r_s2_a.is_nar;

    assign InRemain2    = r_s2_b.remain;
    assign Sign2        = r_s2_b.sign;
    assign RegimeValue2 = r_s2_b.regime;
    assign Exponent2    = r_s2_b.exponent;
    assign Mantissa2    = r_s2_b.mantissa;
    assign IsZero2      = r_s2_b.is_zero;
    assign IsNaR2       = r_s2_b.is_nar;

endmodule

// File: tb/tb_posit_operand_extract.sv
// Directed bench for posit_operand_extract (N=8, ES=3).
// Define POSIT_EXTRACT_SPECIAL_EN for both RTL and bench to test specials.
module tb_posit_operand_extract;
    import posit_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [N-2:0]  InRemain1, InRemain2;
    logic          Sign1, Sign2;
    logic [RS:0]   RegimeValue1, RegimeValue2;
    logic [ES-1:0] Exponent1, Exponent2;
    logic [MW-1:0] Mantissa1, Mantissa2;
    logic          IsZero1, IsZero2;
    logic          IsNaR1, IsNaR2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pop   = 0;
    bit          sb_on   = 1'b0;
    logic [13:0] exp_q[$];
    logic [13:0] sb_e;

    posit_operand_extract dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .InRemain1    (InRemain1),
        .InRemain2    (InRemain2),
        .Sign1        (Sign1),
        .Sign2        (Sign2),
        .RegimeValue1 (RegimeValue1),
        .RegimeValue2 (RegimeValue2),
        .Exponent1    (Exponent1),
        .Exponent2    (Exponent2),
        .Mantissa1    (Mantissa1),
        .Mantissa2    (Mantissa2),
        .IsZero1      (IsZero1),
        .IsZero2      (IsZero2),
        .IsNaR1       (IsNaR1),
        .IsNaR2       (IsNaR2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One pair through an empty pipe; returns when out_valid shows.
    task automatic run_pair(input logic [7:0] a, input logic [7:0] b);
        int lat;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 2);
    endtask

    task automatic exp_a(input string t, input logic s,
                         input logic [6:0] r, input logic [3:0] rv,
                         input logic [2:0] e, input logic [7:0] m);
        chk({t, ".sign1"}, Sign1, s);
        chk({t, ".rem1"}, InRemain1, r);
        chk({t, ".rv1"}, RegimeValue1, rv);
        chk({t, ".exp1"}, Exponent1, e);
        chk({t, ".man1"}, Mantissa1, m);
    endtask

    task automatic exp_b(input string t, input logic s,
                         input logic [6:0] r, input logic [3:0] rv,
                         input logic [2:0] e, input logic [7:0] m);
        chk({t, ".sign2"}, Sign2, s);
        chk({t, ".rem2"}, InRemain2, r);
        chk({t, ".rv2"}, RegimeValue2, rv);
        chk({t, ".exp2"}, Exponent2, e);
        chk({t, ".man2"}, Mantissa2, m);
    endtask

    // Scoreboard: outputs must match accepted inputs in order.
    always @(negedge clk) begin
        if (sb_on && rst_n && out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_rem1", InRemain1, sb_e[13:7]);
                chk("sb_rem2", InRemain2, sb_e[6:0]);
            end
        end
    end

    // Drive the next pair if any remain and log transfers.
    task automatic bp_cycle(inout int i, input int lim);
        in_valid = (i < lim);
        in_a     = 8'(8'h11 + i);
        in_b     = 8'(8'h21 + i);
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back({in_a[6:0], in_b[6:0]});
            i++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int i;
        int c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rv1", RegimeValue1, 0);
        chk("rst_man1", Mantissa1, 0);
        chk("rst_rem2", InRemain2, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_pair(8'h40, 8'h01);
        exp_a("v40", 1'b0, 7'h40, 4'h0, 3'd0, 8'h40);
        exp_b("v01", 1'b0, 7'h01, 4'hA, 3'd0, 8'h40);

        run_pair(8'h5A, 8'h7F);
        exp_a("v5A", 1'b0, 7'h5A, 4'h0, 3'd6, 8'h60);
        exp_b("v7F", 1'b0, 7'h7F, 4'h6, 3'd0, 8'h40);

        run_pair(8'hC0, 8'hA6);
        exp_a("vC0", 1'b1, 7'h40, 4'h0, 3'd0, 8'h40);
        exp_b("vA6", 1'b1, 7'h5A, 4'h0, 3'd6, 8'h60);

        run_pair(8'h2B, 8'h68);
        exp_a("v2B", 1'b0, 7'h2B, 4'hF, 3'd2, 8'h70);
        exp_b("v68", 1'b0, 7'h68, 4'h1, 3'd4, 8'h40);

        run_pair(8'h00, 8'h80);
`ifdef POSIT_EXTRACT_SPECIAL_EN
        exp_a("v00", 1'b0, 7'h00, 4'h0, 3'd0, 8'h00);
        exp_b("v80", 1'b1, 7'h00, 4'h0, 3'd0, 8'h00);
        chk("v00.zero1", IsZero1, 1);
        chk("v00.nar1", IsNaR1, 0);
        chk("v80.zero2", IsZero2, 0);
        chk("v80.nar2", IsNaR2, 1);
`else
        exp_a("v00", 1'b0, 7'h00, 4'h9, 3'd0, 8'h40);
        exp_b("v80", 1'b1, 7'h00, 4'h9, 3'd0, 8'h40);
        chk("v00.zero1", IsZero1, 0);
        chk("v80.nar2", IsNaR2, 0);
`endif
        @(posedge clk);
        #1;
        chk("drain_valid", out_valid, 0);

        // Back-pressure: four pairs offered, output stalled 5 cycles.
        sb_on     = 1'b1;
        n_pop     = 0;
        out_ready = 1'b0;
        i         = 0;
        for (int k = 0; k < 5; k++) begin
            bp_cycle(i, 4);
        end
        chk("bp_accepts", i, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_rem1", InRemain1, 7'h11);
        chk("bp_hold_rem2", InRemain2, 7'h21);
        chk("bp_no_pop", n_pop, 0);
        out_ready = 1'b1;
        c         = 0;
        while ((i < 4 || n_pop < 4) && c < 50) begin
            bp_cycle(i, 4);
            c++;
        end
        in_valid = 1'b0;
        chk("bp_all_in", i, 4);
        chk("bp_pops", n_pop, 4);
        chk("bp_q_empty", exp_q.size(), 0);

        // Mid-stream reset with two pairs in flight.
        n_pop     = 0;
        out_ready = 1'b0;
        i         = 0;
        for (int k = 0; k < 3; k++) begin
            bp_cycle(i, 2);
        end
        chk("mr_loaded", i, 2);
        chk("mr_valid_pre", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid_drop", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_rem1_clr", InRemain1, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mr_no_output", n_pop, 0);
        chk("mr_valid_post", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
